spi_arbiter: RTL and testbench

- Round-robin arbiter and transaction sequencer that shares one 16-bit SPI master between N_REQ requesters.
- Accepts word-write requests, grants one requester at a time, and latches that requester's data word.
- Launches the SPI master and waits for its completion, or times out, then reports done or error back to the granted requester.
- Sits between the register/host-side clients and the SPI master serializer.

---
 rtl/spi_pkg.sv | 25 ++
 rtl/rr_pick.sv | 36 +++
 rtl/spi_arbiter.sv | 100 ++++++++++
 tb/tb_spi_arbiter.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types for the SPI arbiter: FSM encoding, transaction result codes
// and the round-robin pointer advance helper.
package spi_pkg;

   localparam int DATA_W_DEF = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ISSUE  = 2'd1,
      WAIT   = 2'd2,
      FINISH = 2'd3
   } state_e;

   typedef enum logic {
      RES_OK      = 1'b0,
      RES_TIMEOUT = 1'b1
   } result_e;

   // Pointer moves one past the requester just served, wrapping at n.
   function automatic logic [2:0] next_ptr(input logic [2:0] id, input int n);
      if (int'(id) >= n - 1) return 3'd0;
      return id + 3'd1;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request bit at or above the
// pointer, wrapping at N_REQ.
module rr_pick #(
   parameter int N_REQ = 4
) (
   input  logic [N_REQ-1:0] req,
   input  logic [2:0]       ptr,
   output logic [N_REQ-1:0] gnt,
   output logic [2:0]       idx,
   output logic             any
);

   function automatic int slot(input logic [2:0] p, input int off);
      int s;
      s = int'(p) + off;
      if (s >= N_REQ) s = s - N_REQ;
      return s;
   endfunction

   // Outer loop walks priority order, inner loop keeps every index constant.
   always_comb begin
      gnt = '0;
      idx = '0;
      any = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         for (int k = 0; k < N_REQ; k++) begin
            if (!any && req[k] && (k == slot(ptr, i))) begin
               any    = 1'b1;
               gnt[k] = 1'b1;
               idx    = 3'(k);
            end
         end
      end
   end

endmodule

// File: rtl/spi_arbiter.sv
// Round-robin arbiter and transaction sequencer sharing one SPI master
// between N_REQ word-write requesters, with a WAIT-state timeout.
module spi_arbiter
   import spi_pkg::*;
#(
   parameter int N_REQ   = 4,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int TIMEOUT = 64,
   parameter int CNT_W   = 7
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [N_REQ-1:0]        req,
   input  logic [N_REQ*DATA_W-1:0] req_data,
   output logic [N_REQ-1:0]        gnt,
   output logic [N_REQ-1:0]        done,
   output logic                    err,
   output logic [2:0]              active_id,
   output logic                    spi_start,
   output logic [DATA_W-1:0]       spi_data,
   input  logic                    spi_done
);

   state_e              state;
   logic [2:0]          ptr;
   logic [CNT_W-1:0]    cnt;
   logic [N_REQ-1:0]    pick_gnt;
   logic [2:0]          pick_idx;
   logic                pick_any;
   logic [DATA_W-1:0]   pick_data;
   logic                timeout_hit;
   result_e             wait_res;

   rr_pick #(.N_REQ(N_REQ)) u_pick (
      .req (req),
      .ptr (ptr),
      .gnt (pick_gnt),
      .idx (pick_idx),
      .any (pick_any)
   );

   always_comb begin
      pick_data = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (pick_gnt[k]) pick_data = pick_data | req_data[k*DATA_W +: DATA_W];
      end
   end

   // A spi_done on the final WAIT cycle beats the timeout.
   assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));
   assign wait_res    = spi_done ? RES_OK : RES_TIMEOUT;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         ptr       <= '0;
         cnt       <= '0;
         gnt       <= '0;
         done      <= '0;
         err       <= 1'b0;
         active_id <= '0;
         spi_start <= 1'b0;
         spi_data  <= '0;
      end else begin
         spi_start <= 1'b0;
         done      <= '0;
         err       <= 1'b0;
         case (state)
            IDLE: begin
               if (pick_any) begin
                  gnt       <= pick_gnt;
                  active_id <= pick_idx;
                  spi_data  <= pick_data;
                  spi_start <= 1'b1;
                  state     <= ISSUE;
               end
            end
            ISSUE: begin
               cnt   <= '0;
               state <= WAIT;
            end
            WAIT: begin
               cnt <= cnt + 1'b1;
               if (spi_done || timeout_hit) begin
                  state <= FINISH;
                  if (wait_res == RES_OK) done <= gnt;
                  else                    err  <= 1'b1;
               end
            end
            FINISH: begin
               gnt   <= '0;
               ptr   <= next_ptr(active_id, N_REQ);
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_arbiter.sv
// Directed bench for spi_arbiter with a scoreboard of expected grants and an
// inline SPI master model driving spi_done.
module tb_spi_arbiter;

   localparam int N  = 4;
   localparam int DW = 16;

   logic            clk = 1'b0;
   logic            reset = 1'b0;
   logic [N-1:0]    req = '0;
   logic [N*DW-1:0] req_data = '0;
   logic [N-1:0]    gnt;
   logic [N-1:0]    done;
   logic            err;
   logic [2:0]      active_id;
   logic            spi_start;
   logic [DW-1:0]   spi_data;
   logic            spi_done = 1'b0;

   typedef struct {
      logic [N-1:0]  gnt;
      logic [2:0]    id;
      logic [DW-1:0] data;
   } exp_t;

   exp_t sb[$];
   int   vectors = 0;
   int   miscompares = 0;

   spi_arbiter #(.N_REQ(N), .DATA_W(DW), .TIMEOUT(64), .CNT_W(7)) dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .req_data  (req_data),
      .gnt       (gnt),
      .done      (done),
      .err       (err),
      .active_id (active_id),
      .spi_start (spi_start),
      .spi_data  (spi_data),
      .spi_done  (spi_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_word(input int id, input logic [DW-1:0] w);
      req_data[id*DW +: DW] = w;
   endtask

   task automatic push(input int id);
      exp_t e;
      e.gnt  = N'(1) << id;
      e.id   = 3'(id);
      e.data = req_data[id*DW +: DW];
      sb.push_back(e);
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_gnt"}, 32'(gnt), 32'h0);
      chk({tag, "_done"}, 32'(done), 32'h0);
      chk({tag, "_err"}, 32'(err), 32'h0);
      chk({tag, "_start"}, 32'(spi_start), 32'h0);
   endtask

   // Wait for spi_start, compare against the scoreboard head, then answer
   // with spi_done lat cycles after start (lat==0: never answer).
   task automatic serve(input string tag, input int lat, input logic [N-1:0] mid_req,
                        input logic [N-1:0] fin_req);
      exp_t e;
      bit   seen;
      seen = 1'b0;
      for (int n = 0; n < 16 && !seen; n++) begin
         @(negedge clk);
         if (spi_start) seen = 1'b1;
      end
      chk({tag, "_start_seen"}, 32'(seen), 32'h1);
      if (!seen) return;
      if (sb.size() == 0) begin
         chk({tag, "_sb_nonempty"}, 32'h0, 32'h1);
         return;
      end
      e = sb.pop_front();
      chk({tag, "_gnt"}, 32'(gnt), 32'(e.gnt));
      chk({tag, "_id"}, 32'(active_id), 32'(e.id));
      chk({tag, "_data"}, 32'(spi_data), 32'(e.data));
      req = mid_req;
      @(negedge clk);
      chk({tag, "_start_pulse"}, 32'(spi_start), 32'h0);
      chk({tag, "_data_hold"}, 32'(spi_data), 32'(e.data));
      if (lat > 0) begin
         repeat (lat - 1) @(negedge clk);
         chk({tag, "_quiet"}, 32'({done, err}), 32'h0);
         spi_done = 1'b1;
         @(negedge clk);
         spi_done = 1'b0;
         chk({tag, "_done"}, 32'(done), 32'(e.gnt));
         chk({tag, "_err0"}, 32'(err), 32'h0);
      end else begin
         repeat (64) @(negedge clk);
         chk({tag, "_err"}, 32'(err), 32'h1);
         chk({tag, "_done0"}, 32'(done), 32'h0);
      end
      chk({tag, "_gnt_fin"}, 32'(gnt), 32'(e.gnt));
      req = fin_req;
      @(negedge clk);
      chk({tag, "_gnt_clr"}, 32'(gnt), 32'h0);
      chk({tag, "_pulse_end"}, 32'({done, err}), 32'h0);
   endtask

   initial begin
      bit seen;
      exp_t e;

      // Reset state
      @(negedge clk);
      chk_idle("rst");
      chk("rst_data", 32'(spi_data), 32'h0);
      chk("rst_id", 32'(active_id), 32'h0);
      @(negedge clk);
      reset = 1'b1;

      // Round robin, all four requesting
      set_word(0, 16'h1111); set_word(1, 16'h2222);
      set_word(2, 16'h3333); set_word(3, 16'h4444);
      req = 4'b1111;
      push(0); push(1); push(2); push(3); push(0);
      serve("rr0", 5,  4'b1111, 4'b1111);
      serve("rr1", 10, 4'b1111, 4'b1111);
      serve("rr2", 3,  4'b1111, 4'b1111);
      serve("rr3", 8,  4'b1111, 4'b1111);
      serve("rr4", 6,  4'b1111, 4'b0000);

      // Single request, dropped mid-transaction
      set_word(1, 16'hA5C3);
      req = 4'b0010; push(1);
      serve("single", 34, 4'b0000, 4'b0000);

      // Wrap: id3, then 1001 gives id0, then id3
      set_word(0, 16'h0F0F); set_word(3, 16'hF0F0);
      req = 4'b1000; push(3);
      serve("wrap3", 4, 4'b1000, 4'b1001);
      push(0);
      serve("wrap0", 4, 4'b1001, 4'b1001);
      push(3);
      serve("wrap3b", 4, 4'b1001, 4'b0000);

      // Stray spi_done in IDLE
      @(negedge clk);
      spi_done = 1'b1;
      @(negedge clk);
      spi_done = 1'b0;
      chk_idle("stray1");
      @(negedge clk);
      chk_idle("stray2");

      // Timeout on id0, then pending id2 served normally
      set_word(0, 16'hDEAD); set_word(2, 16'hBEEF);
      req = 4'b0101; push(0);
      serve("tmo", 0, 4'b0101, 4'b0100);
      push(2);
      serve("after_tmo", 12, 4'b0100, 4'b0000);

      // spi_done on the last WAIT cycle, then back-to-back for one requester
      set_word(1, 16'h7E57);
      req = 4'b0010; push(1); push(1);
      serve("edge", 64, 4'b0010, 4'b0010);
      serve("b2b", 3, 4'b0010, 4'b0000);

      // Reset in the middle of WAIT
      set_word(0, 16'h0BAD);
      req = 4'b0001; push(0);
      seen = 1'b0;
      for (int n = 0; n < 16 && !seen; n++) begin
         @(negedge clk);
         if (spi_start) seen = 1'b1;
      end
      chk("mrst_start_seen", 32'(seen), 32'h1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk("mrst_id", 32'(active_id), 32'(e.id));
      end
      repeat (5) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      chk_idle("mrst_async");
      chk("mrst_data", 32'(spi_data), 32'h0);
      req = 4'b0000;
      repeat (2) @(negedge clk);
      chk_idle("mrst_hold");
      reset = 1'b1;
      repeat (3) @(negedge clk);
      chk_idle("mrst_after");

      // Pointer back at 0: 1001 gives id0, then id2 from 0100
      set_word(0, 16'hC0DE); set_word(3, 16'h3333); set_word(2, 16'h5A5A);
      req = 4'b1001; push(0);
      serve("post_rst0", 7, 4'b1001, 4'b0100);
      push(2);
      serve("post_rst2", 9, 4'b0100, 4'b0000);

      chk("sb_drained", 32'(sb.size()), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
